// File: rtl/edge_pkg.sv
// edge_pkg: shared state encoding, default width and length helper for edge_waveform_gen
package edge_pkg;
    typedef enum logic {ST_IDLE, ST_DRIVE} state_t;
    localparam int DEF_CNT_W = 8;
    function automatic int unsigned min_len1(input int unsigned n);
        return (n == 0) ? 32'd1 : n;
    endfunction
endpackage

// File: rtl/edge_waveform_gen_if.sv
// edge_waveform_gen_if: command handshake plus generated waveform and status
//   cmd_valid/cmd_ready/cmd_level/cmd_len : command channel (source -> generator)
//   out_line/pose/nege/busy/done          : waveform and status (generator -> consumer)
interface edge_waveform_gen_if import edge_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_level;
    logic [CNT_W-1:0] cmd_len;
    logic             out_line;
    logic             pose;
    logic             nege;
    logic             busy;
    logic             done;
    modport master(output cmd_valid, cmd_level, cmd_len, input cmd_ready, out_line, pose, nege, busy, done);
    modport slave(input cmd_valid, cmd_level, cmd_len, output cmd_ready, out_line, pose, nege, busy, done);
endinterface

// File: rtl/seg_counter.sv
// seg_counter: loadable down-counter of remaining segment cycles
//   clk, rst : clock, sync active-high reset
//   load     : load load_val (has priority over en)
//   en       : decrement, saturating at 0
//   last     : remaining count is 1
module seg_counter #(parameter int CNT_W = 8) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             last
);
    logic [CNT_W-1:0] rem;
    assign last = rem == CNT_W'(1);
    always_ff @(posedge clk) begin
        if (rst) rem <= '0;
        else if (load) rem <= load_val;
        else if (en && rem != '0) rem <= rem - CNT_W'(1);
    end
endmodule

// File: rtl/edge_waveform_gen.sv
// edge_waveform_gen: turns (level, length) commands into a timed waveform with edge flags
//   clk, rst : clock, sync active-high reset
//   bus      : slave side of edge_waveform_gen_if (command in, out_line/pose/nege/busy/done out)
module edge_waveform_gen import edge_pkg::*; #(
    parameter int   CNT_W      = DEF_CNT_W,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic clk,
    input logic rst,
    edge_waveform_gen_if.slave bus
);
    state_t state, state_n;
    logic acc, last, seg_end;
    logic line, pose, nege, done;
    logic line_n, pose_n, nege_n, done_n;
    logic [CNT_W-1:0] len1;
    assign seg_end = state == ST_DRIVE && last;
    assign bus.cmd_ready = !rst && (state == ST_IDLE || seg_end);
    assign acc = bus.cmd_valid && bus.cmd_ready;
    assign len1 = CNT_W'(min_len1(32'(bus.cmd_len)));
    seg_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (acc),
        .load_val (len1),
        .en       (state == ST_DRIVE),
        .last     (last)
    );
    always_comb begin
        state_n = acc ? ST_DRIVE : seg_end ? ST_IDLE : state;
        line_n  = acc ? bus.cmd_level : line;
        pose_n  = line_n && !line;
        nege_n  = !line_n && line;
        // done only when a segment ends with nothing queued behind it
        done_n  = seg_end && !acc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            line  <= IDLE_LEVEL;
            pose  <= 1'b0;
            nege  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            line  <= line_n;
            pose  <= pose_n;
            nege  <= nege_n;
            done  <= done_n;
        end
    end
    assign bus.out_line = line;
    assign bus.pose     = pose;
    assign bus.nege     = nege;
    assign bus.done     = done;
    assign bus.busy     = state == ST_DRIVE;
endmodule

// File: doc/edge_waveform_gen.md
Name: edge_waveform_gen

Overview:
Transmit-side counterpart to our edge detector. It turns a stream of (level, duration) commands into a single-bit output line with exactly timed rising and falling edges. It flags each edge it generates, so downstream stimulus and loopback logic can compare against the detector's e/pose/nege outputs. It sits between a command source, such as a test sequencer or protocol encoder, and any pin or net driven by an edge-coded waveform.

Parameters:
- CNT_W, 8, width of the segment-length field; max segment is 2^CNT_W-1 cycles.
- IDLE_LEVEL, 1'b0, value of out_line after reset.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, synchronous, active-high reset.
- cmd_valid, input, 1, command present.
- cmd_ready, output, 1, block can accept a command this cycle.
- cmd_level, input, 1, level to drive for the segment.
- cmd_len, input, CNT_W, segment length in cycles; 0 is treated as 1.
- out_line, output, 1, generated waveform (registered).
- pose, output, 1, one-cycle flag coincident with out_line rising.
- nege, output, 1, one-cycle flag coincident with out_line falling.
- busy, output, 1, a segment is being driven.
- done, output, 1, one-cycle pulse when the last queued segment ends.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on posedge clk.
- Reset values: state=IDLE, out_line=IDLE_LEVEL, pose=nege=done=busy=0, counter=0.
- States:
  - IDLE: not driving a segment.
  - DRIVE: driving a segment, with counter `rem` holding the remaining cycles including the current one.
- Handshake:
  - A command is accepted in any cycle where cmd_valid && cmd_ready.
  - cmd_ready = !rst && (state==IDLE || (state==DRIVE && rem==1)).
  - cmd_ready depends only on state and never on cmd_valid.
  - cmd_level and cmd_len are sampled only on acceptance. A source holding cmd_valid while cmd_ready=0 stalls with no loss.
- Timing, for a command accepted in cycle N with L = max(cmd_len,1):
  - In cycles N+1..N+L, state=DRIVE, busy=1, out_line=cmd_level, and rem counts L..1.
  - If a command is accepted in cycle N+L, its segment starts in N+L+1 with no gap.
  - Otherwise, in cycle N+L+1 the state returns to IDLE, busy=0 and done=1 for that single cycle.
- out_line retains the last segment level while IDLE. It returns to IDLE_LEVEL only on reset.
- Edge flags are registered and coincide with the first cycle of the new level:
  - pose = next out_line && !current out_line.
  - nege = !next out_line && current out_line.
  - Consecutive segments at the same level produce no flag.
  - A first segment whose level equals IDLE_LEVEL produces no flag.
- done and pose/nege can assert in the same cycle only if that is consistent with the rules above. In practice they are exclusive, because done is asserted only when no new segment starts.
- Width: rem is CNT_W bits. cmd_len=2^CNT_W-1 holds for exactly that many cycles, and the counter never wraps.
- Reset mid-segment: on the next edge all outputs go to their reset values with no done pulse. A command presented during the rst cycle is not accepted.

Decomposition:
- Shared package edge_pkg holds:
  - the state encodings ST_IDLE and ST_DRIVE;
  - the default CNT_W;
  - a helper that maps length 0 to 1.
- One sub-module, seg_counter, is a CNT_W-bit loadable down-counter with inputs load, load_val and en, and output last (rem==1).
- The FSM, handshake and edge-flag logic live in the top module.

Test Plan:
- Reset: rst high for 2 cycles while cmd_valid=1 → no accept; out_line=0, pose=nege=busy=done=0; cmd_ready=1 in the first cycle after rst falls.
- Single segment: (level=1, len=3) accepted in cycle 5 → out_line=1 in cycles 6-8, pose=1 only in cycle 6, busy=1 in cycles 6-8, done=1 in cycle 9, out_line still 1 in cycle 9.
- Back-to-back and stall: hold cmd_valid with (1,2) then (0,4):
  - cmd_ready is low in the first drive cycle and high in the last;
  - out_line=1 for exactly 2 cycles, then 0 for exactly 4 cycles with no gap;
  - one pose, one nege, and a single done after the 4th zero cycle.
- Same level: (1,2) then (1,2) → out_line high for 4 contiguous cycles, a single pose, no nege.
- Length zero: (1,0) → out_line=1 for exactly 1 cycle; done in the following cycle; max length (1,255) → exactly 255 high cycles.
- Reset mid-operation: (1,10) accepted, then rst in the 4th drive cycle → next cycle out_line=0, busy=0, done=0, no pose/nege; a command presented during rst is ignored.
